id_scoreboard: RTL and testbench
================================

# id_scoreboard

Parametrised register scoreboard for the decode stage of the pipelined CPU. It replaces the per-stage destination-compare hazard check with per-register in-flight write counters. It decides when decode may complete (`id_over`), tracks outstanding writes from issue to write-back, and supports stall-on-any-pending and forwarding-aware (stall-on-load-only) modes. It sits beside decode, fed by decode's source/destination fields and by the MEM/WB retire buses.

## Interface
- `NREG`, 32: architectural registers; register 0 is never tracked.
- `AW`, $clog2(NREG): register address width.
- `NSRC`, 2: source operands checked per instruction.
- `CNT_W`, 2: counter width; at most 2^CNT_W-1 in-flight writes per register.
- `FWD_EN`, 0: 0 stalls on any pending write; 1 stalls only on a pending load (bypass network assumed downstream).

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  decode holds a valid instruction.
- `id_src`  in  NSRC*AW  source register numbers, source i at [i*AW +: AW].
- `id_src_en`  in  NSRC  source i is actually read; clear for immediates and unused fields.
- `id_wen`  in  1  instruction writes the register file.
- `id_wdest`  in  AW  destination register.
- `id_is_load`  in  1  instruction is a load.
- `exe_allowin`  in  1  EXE can accept an instruction this cycle.
- `mem_ld_done`  in  1  a load's data is available at MEM output this cycle.
- `mem_ld_dest`  in  AW  destination of that load.
- `wb_retire`  in  1  WB writes the register file this cycle.
- `wb_dest`  in  AW  destination written by WB.
- `flush`  in  1  synchronous clear of all tracking (exception/ERET).
- `id_stall`  out  1  decode must hold.
- `id_over`  out  1  decode completes; equals `id_valid & ~id_stall & exe_allowin`.
- `sb_empty`  out  1  no register has a pending write.
- `sb_err`  out  1  sticky error: retire or load-done seen with a zero counter.

## Operation
- State per register r (1..NREG-1): `pend[r]` (CNT_W bits) and `ldp[r]` (CNT_W bits).
- Source hazard i: `id_src_en[i] & src_i!=0 & (FWD_EN ? ldp[src_i]!=0 : pend[src_i]!=0)`.
- Structural hazard: `id_wen & id_wdest!=0 & pend[id_wdest]==max`.
- `id_stall = id_valid & (any source hazard | structural hazard)`.
- Issue (on `id_over & id_wen & id_wdest!=0`):
  - `pend[id_wdest]` +1.
  - If `id_is_load`, `ldp[id_wdest]` +1.
- Retire: `wb_retire & wb_dest!=0` decrements `pend[wb_dest]`.
- Load data ready: `mem_ld_done & mem_ld_dest!=0` decrements `ldp[mem_ld_dest]`.
- Issue and decrement on the same register in the same cycle: net change 0.
- Decrement at zero: counter holds at 0 and `sb_err` is set.
- `flush`: clears all counters next edge and overrides all other events. `sb_err` is unaffected.
- Writes to register 0 are ignored everywhere.

## Timing
- Reset: all counters 0; `sb_empty`=1, `sb_err`=0. `id_stall`=0 and `id_over` follows `id_valid & exe_allowin`.
- `id_stall`/`id_over` are combinational from the registered counters and current inputs. There is no bypass from same-cycle retire.
- A retire in cycle N releases a stall in cycle N+1.
- An issue in cycle N is visible to the next instruction's check in cycle N+1, giving back-to-back RAW detection.
- `sb_empty` and `sb_err` are registered-state derived and update one cycle after the event.
- Reset asserted mid-operation clears all state immediately (asynchronous). Flush takes effect at the next edge.

## Structure
- Shared package `sb_pkg`:
  - `NREG`/`CNT_W` defaults;
  - counter typedef `sb_cnt_t`;
  - localparam `SB_CNT_MAX`.
- Sub-module `sb_counter`:
  - one per tracked register;
  - up/down saturating counter with simultaneous inc/dec, sync clear and zero-decrement error output;
  - instantiated twice per register (pend, ldp) via generate.
- The top level contains the source-hazard OR trees, the structural check and the `sb_err` sticky flop.

## Test plan
- Reset, then issue `addu` to r5, and next cycle an instruction reading r5 with FWD_EN=0 → `id_stall`=1 until the cycle after `wb_retire`/`wb_dest`=5. Then `id_over`=1.
- FWD_EN=1: issue `lw` to r7, then a reader of r7 → stalls until the cycle after `mem_ld_done`/dest 7. An ALU producer of r8 followed by a reader of r8 → no stall.
- CNT_W=2: three issues to r3 without retire → `pend[3]`=3. A fourth writer of r3 → `id_stall`=1 until one retire.
- Same-cycle issue to r4 and retire of r4 with `pend[4]`=1 → `pend[4]` stays 1 and `sb_empty`=0.
- `wb_retire` to r9 with `pend[9]`=0 → `sb_err`=1 next cycle and stays 1 through a flush. Counter stays 0.
- Fill several counters, assert `flush` → `sb_empty`=1 next cycle. Then assert `reset` mid-stream → all outputs return to reset values immediately.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared scoreboard defaults and counter type for the decode-stage register scoreboard.
package sb_pkg;
  localparam int SB_NREG  = 32;
  localparam int SB_CNT_W = 2;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;
endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight counter: saturating up/down, sync clear, flags a decrement seen at zero.
module sb_counter import sb_pkg::*; #(
  parameter int W = SB_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);
  localparam logic [W-1:0] MAX = '1;

  // A decrement with nothing outstanding means the retire bus disagrees with issue.
  assign err = dec & (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (clr)                       cnt <= '0;
    else if (inc & ~dec) begin
      if (cnt != MAX)                   cnt <= cnt + 1'b1;
    end else if (dec & ~inc & (cnt != '0)) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write/pending-load counters
// gating decode completion, with stall-on-any or stall-on-load-only hazard policy.
module id_scoreboard import sb_pkg::*; #(
  parameter int NREG   = SB_NREG,
  parameter int AW     = $clog2(NREG),
  parameter int NSRC   = 2,
  parameter int CNT_W  = SB_CNT_W,
  parameter int FWD_EN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [NSRC*AW-1:0] id_src,
  input  logic [NSRC-1:0]   id_src_en,
  input  logic              id_wen,
  input  logic [AW-1:0]     id_wdest,
  input  logic              id_is_load,
  input  logic              exe_allowin,
  input  logic              mem_ld_done,
  input  logic [AW-1:0]     mem_ld_dest,
  input  logic              wb_retire,
  input  logic [AW-1:0]     wb_dest,
  input  logic              flush,
  output logic              id_stall,
  output logic              id_over,
  output logic              sb_empty,
  output logic              sb_err
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] pend, ldp;
  logic [NREG-1:0]            pend_err, ldp_err;
  logic [NSRC-1:0]            src_haz;
  logic                       struct_haz, issue;

  // r0 is hardwired zero, so it never holds a pending write.
  assign pend[0]     = '0;
  assign ldp[0]      = '0;
  assign pend_err[0] = 1'b0;
  assign ldp_err[0]  = 1'b0;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [AW-1:0] s;
    assign s = id_src[i*AW +: AW];
    assign src_haz[i] = id_src_en[i] & (s != '0) &
                        ((FWD_EN != 0) ? (ldp[s] != '0) : (pend[s] != '0));
  end

  // A saturated counter cannot absorb another writer.
  assign struct_haz = id_wen & (id_wdest != '0) & (pend[id_wdest] == CNT_MAX);
  assign id_stall   = id_valid & ((|src_haz) | struct_haz);
  assign id_over    = id_valid & ~id_stall & exe_allowin;
  assign issue      = id_over & id_wen & (id_wdest != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic hit;
    assign hit = (id_wdest == AW'(r));

    sb_counter #(.W(CNT_W)) u_pend (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (issue & hit),
      .dec   (wb_retire & (wb_dest == AW'(r))),
      .cnt   (pend[r]),
      .err   (pend_err[r])
    );

    sb_counter #(.W(CNT_W)) u_ldp (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (issue & hit & id_is_load),
      .dec   (mem_ld_done & (mem_ld_dest == AW'(r))),
      .cnt   (ldp[r]),
      .err   (ldp_err[r])
    );
  end

  assign sb_empty = ~|pend;

  // Sticky until reset; flush deliberately leaves it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      sb_err <= 1'b0;
    else if (|pend_err | |ldp_err)  sb_err <= 1'b1;
  end
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: a FWD_EN=0 and a FWD_EN=1 instance share stimulus; both are
// checked every cycle against a counter-array model, plus directed table and sequences.
module tb_id_scoreboard;
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic rst;
  logic v, wen, ld, alw, lddn, ret, fl;
  logic [9:0] src;
  logic [1:0] src_en;
  logic [4:0] wd, ldd, wbd;
  logic st0, ov0, em0, er0, st1, ov1, em1, er1;

  int vectors = 0;
  int miscompares = 0;

  int pend [2][32];
  int ldp  [2][32];
  logic merr [2];

  always #5 clk = ~clk;

  id_scoreboard #(.FWD_EN(0)) u_dut0 (
    .clk(clk), .reset(rst), .id_valid(v), .id_src(src), .id_src_en(src_en),
    .id_wen(wen), .id_wdest(wd), .id_is_load(ld), .exe_allowin(alw),
    .mem_ld_done(lddn), .mem_ld_dest(ldd), .wb_retire(ret), .wb_dest(wbd),
    .flush(fl), .id_stall(st0), .id_over(ov0), .sb_empty(em0), .sb_err(er0));

  id_scoreboard #(.FWD_EN(1)) u_dut1 (
    .clk(clk), .reset(rst), .id_valid(v), .id_src(src), .id_src_en(src_en),
    .id_wen(wen), .id_wdest(wd), .id_is_load(ld), .exe_allowin(alw),
    .mem_ld_done(lddn), .mem_ld_dest(ldd), .wb_retire(ret), .wb_dest(wbd),
    .flush(fl), .id_stall(st1), .id_over(ov1), .sb_empty(em1), .sb_err(er1));

  typedef struct {
    logic v; logic [4:0] s0, s1; logic [1:0] en; logic wen; logic [4:0] wd; logic ld;
    logic alw; logic lddn; logic [4:0] ldd; logic ret; logic [4:0] wbd; logic fl;
    logic e_st, e_ov, e_em, e_er;
  } vec_t;

  function automatic vec_t mk(input int v_, s0, s1, en, wen_, wd_, ld_, alw_, lddn_, ldd_,
                              ret_, wbd_, fl_, st, ov, em, er);
    vec_t t;
    t.v = 1'(v_); t.s0 = 5'(s0); t.s1 = 5'(s1); t.en = 2'(en); t.wen = 1'(wen_);
    t.wd = 5'(wd_); t.ld = 1'(ld_); t.alw = 1'(alw_); t.lddn = 1'(lddn_); t.ldd = 5'(ldd_);
    t.ret = 1'(ret_); t.wbd = 5'(wbd_); t.fl = 1'(fl_);
    t.e_st = 1'(st); t.e_ov = 1'(ov); t.e_em = 1'(em); t.e_er = 1'(er);
    return t;
  endfunction

  function automatic void chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endfunction

  // Reference: stall if any enabled nonzero source has outstanding work of the relevant
  // kind, or the destination already holds the maximum number of in-flight writes.
  function automatic logic mstall(input int m);
    logic h = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int s = (i == 0) ? int'(src[4:0]) : int'(src[9:5]);
      int c = (m == 1) ? ldp[m][s] : pend[m][s];
      if (src_en[i] && s != 0 && c != 0) h = 1'b1;
    end
    if (wen && wd != 0 && pend[m][wd] == MAXC) h = 1'b1;
    return v & h;
  endfunction

  function automatic logic mempty(input int m);
    for (int r = 0; r < 32; r++) if (pend[m][r] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void mreset();
    for (int m = 0; m < 2; m++) begin
      merr[m] = 1'b0;
      for (int r = 0; r < 32; r++) begin pend[m][r] = 0; ldp[m][r] = 0; end
    end
  endfunction

  function automatic int bump(input int c, input logic up, input logic dn);
    if (up && dn) return c;
    if (up) return (c < MAXC) ? c + 1 : c;
    if (dn) return (c > 0) ? c - 1 : 0;
    return c;
  endfunction

  function automatic void mupdate();
    for (int m = 0; m < 2; m++) begin
      logic over = v & ~mstall(m) & alw;
      for (int r = 1; r < 32; r++) begin
        logic up = over && wen && wd == r;
        logic dp = ret && wbd == r;
        logic dl = lddn && ldd == r;
        if ((dp && pend[m][r] == 0) || (dl && ldp[m][r] == 0)) merr[m] = 1'b1;
        if (fl) begin pend[m][r] = 0; ldp[m][r] = 0; end
        else begin
          pend[m][r] = bump(pend[m][r], up, dp);
          ldp[m][r]  = bump(ldp[m][r], up & ld, dl);
        end
      end
    end
  endfunction

  task automatic apply(input vec_t t);
    v = t.v; src = {t.s1, t.s0}; src_en = t.en; wen = t.wen; wd = t.wd; ld = t.ld;
    alw = t.alw; lddn = t.lddn; ldd = t.ldd; ret = t.ret; wbd = t.wbd; fl = t.fl;
  endtask

  task automatic check_model();
    logic s0m = mstall(0), s1m = mstall(1);
    chk("stall0", st0, s0m);  chk("over0", ov0, v & ~s0m & alw);
    chk("empty0", em0, mempty(0)); chk("err0", er0, merr[0]);
    chk("stall1", st1, s1m);  chk("over1", ov1, v & ~s1m & alw);
    chk("empty1", em1, mempty(1)); chk("err1", er1, merr[1]);
  endtask

  // which: -1 model only, 0 also dut0 vs table, 1 also dut1 vs table
  task automatic step(input int which, input vec_t t);
    apply(t);
    #1;
    check_model();
    if (which == 0) begin
      chk("tbl_stall0", st0, t.e_st); chk("tbl_over0", ov0, t.e_ov);
      chk("tbl_empty0", em0, t.e_em); chk("tbl_err0", er0, t.e_er);
    end else if (which == 1) begin
      chk("seq_stall1", st1, t.e_st); chk("seq_over1", ov1, t.e_ov);
      chk("seq_empty1", em1, t.e_em); chk("seq_err1", er1, t.e_er);
    end
    @(posedge clk);
    mupdate();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mreset();
    #1;
    chk("rst_stall0", st0, 1'b0); chk("rst_over0", ov0, v & alw);
    chk("rst_empty0", em0, 1'b1); chk("rst_err0", er0, 1'b0);
    chk("rst_stall1", st1, 1'b0); chk("rst_over1", ov1, v & alw);
    chk("rst_empty1", em1, 1'b1); chk("rst_err1", er1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl [21];
  vec_t seq [6];

  initial begin
    // v s0 s1 en wen wd ld alw lddn ldd ret wbd fl | st ov em er   (FWD_EN=0 view)
    tbl[0]  = mk(1,0,0,0, 1,5,0,1, 0,0, 0,0, 0,  0,1,1,0);
    tbl[1]  = mk(1,5,0,1, 1,6,0,1, 0,0, 0,0, 0,  1,0,0,0);
    tbl[2]  = mk(1,5,0,1, 1,6,0,1, 0,0, 1,5, 0,  1,0,0,0);
    tbl[3]  = mk(1,5,0,1, 1,6,0,1, 0,0, 0,0, 0,  0,1,1,0);
    tbl[4]  = mk(0,0,0,0, 0,0,0,1, 0,0, 1,6, 0,  0,0,0,0);
    tbl[5]  = mk(1,0,0,0, 1,3,0,1, 0,0, 0,0, 0,  0,1,1,0);
    tbl[6]  = mk(1,0,0,0, 1,3,0,1, 0,0, 0,0, 0,  0,1,0,0);
    tbl[7]  = mk(1,0,0,0, 1,3,0,1, 0,0, 0,0, 0,  0,1,0,0);
    tbl[8]  = mk(1,0,0,0, 1,3,0,1, 0,0, 0,0, 0,  1,0,0,0);
    tbl[9]  = mk(1,0,0,0, 1,3,0,1, 0,0, 1,3, 0,  1,0,0,0);
    tbl[10] = mk(1,0,0,0, 1,3,0,1, 0,0, 0,0, 0,  0,1,0,0);
    tbl[11] = mk(0,0,0,0, 0,0,0,1, 0,0, 0,0, 1,  0,0,0,0);
    tbl[12] = mk(0,0,0,0, 0,0,0,1, 0,0, 0,0, 0,  0,0,1,0);
    tbl[13] = mk(1,0,0,0, 1,4,0,1, 0,0, 0,0, 0,  0,1,1,0);
    tbl[14] = mk(1,0,0,0, 1,4,0,1, 0,0, 1,4, 0,  0,1,0,0);
    tbl[15] = mk(0,0,0,0, 0,0,0,1, 0,0, 0,0, 0,  0,0,0,0);
    tbl[16] = mk(0,0,0,0, 0,0,0,1, 0,0, 1,9, 0,  0,0,0,0);
    tbl[17] = mk(0,0,0,0, 0,0,0,1, 0,0, 0,0, 1,  0,0,0,1);
    tbl[18] = mk(0,0,0,0, 0,0,0,1, 0,0, 0,0, 0,  0,0,1,1);
    tbl[19] = mk(1,0,0,3, 1,0,0,0, 0,0, 0,0, 0,  0,0,1,1);
    tbl[20] = mk(1,4,0,0, 0,0,0,1, 0,0, 0,0, 0,  0,1,1,1);

    // FWD_EN=1 view: load to r7 blocks its reader until load data; ALU r8 does not.
    seq[0] = mk(1,0,0,0, 1,7,1,1, 0,0, 0,0, 0,  0,1,1,0);
    seq[1] = mk(1,7,0,1, 0,0,0,1, 0,0, 0,0, 0,  1,0,0,0);
    seq[2] = mk(1,7,0,1, 0,0,0,1, 1,7, 0,0, 0,  1,0,0,0);
    seq[3] = mk(1,7,0,1, 0,0,0,1, 0,0, 0,0, 0,  0,1,0,0);
    seq[4] = mk(1,0,0,0, 1,8,0,1, 0,0, 0,0, 0,  0,1,0,0);
    seq[5] = mk(1,0,8,2, 0,0,0,1, 0,0, 0,0, 0,  0,1,0,0);

    apply(mk(1,0,0,0, 0,0,0,1, 0,0, 0,0, 0, 0,0,0,0));
    rst = 1'b0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 21; i++) step(0, tbl[i]);

    do_reset();
    for (int i = 0; i < 6; i++) step(1, seq[i]);
    // Same reader under FWD_EN=0 still waits on the outstanding r7/r8 writes.
    apply(seq[5]);
    #1;
    chk("seq_stall0_r8", st0, 1'b1);
    @(negedge clk);

    do_reset();
    for (int n = 0; n < 1500; n++) begin
      vec_t t;
      t = mk($urandom_range(0,3) != 0, $urandom_range(0,7), $urandom_range(0,7),
             $urandom_range(0,3), $urandom_range(0,1), $urandom_range(0,7),
             $urandom_range(0,2) == 0, $urandom_range(0,3) != 0,
             $urandom_range(0,2) == 0, $urandom_range(0,7),
             $urandom_range(0,2) == 0, $urandom_range(0,7),
             $urandom_range(0,60) == 0, 0,0,0,0);
      step(-1, t);
      if (n == 700) do_reset();
    end

    // Mid-stream asynchronous reset with counters populated.
    apply(mk(1,0,0,0, 1,2,1,1, 0,0, 0,0, 0, 0,0,0,0));
    step(-1, mk(1,0,0,0, 1,2,1,1, 0,0, 0,0, 0, 0,0,0,0));
    step(-1, mk(1,2,0,1, 1,3,0,1, 0,0, 0,0, 0, 0,0,0,0));
    apply(mk(1,2,0,1, 1,2,0,1, 0,0, 0,0, 0, 0,0,0,0));
    do_reset();
    step(-1, mk(1,2,0,1, 1,2,0,1, 0,0, 0,0, 0, 0,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
